// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage -- pipeline writeback stage
//
// Purpose:
//   This stage registers the result coming from the MEM stage. It selects the
//   writeback value from three sources: the ALU result, the aligned and
//   extended load data, or the link address (PC+4). It drives the register
//   file write port directly. It also keeps a retired-instruction counter for
//   debug display.
//
//   An instruction captured at edge N drives the outputs during cycle N..N+1.
//   The register file samples it at edge N+1. The "fresh" flag limits each
//   instruction to one write and one count. A stall holds the instruction but
//   clears fresh.
//
// Optional feature (macro WB_BYPASS_EN):
//   When this macro is defined, the stage adds a one-entry "last write"
//   register and exposes it on three outputs: bypass_valid, bypass_addr and
//   bypass_data. bypass_valid is high for exactly one cycle after a write
//   commits. The ID stage uses it to forward across the register file's
//   negedge-read window. When the macro is undefined, those ports and the
//   register do not exist.
//
// Ports:
//   CLOCK, reset        clock and synchronous active-high reset
//   stall, flush        hold the stage / kill the instruction being captured
//   in_*                MEM-stage instruction fields
//   WriteEnable         register file write strobe
//   write_address       register file write address (held field)
//   write_data_in       register file write data (held field)
//   wb_valid            the stage holds a valid instruction
//   misalign_err        one-cycle pulse for a misaligned load
//   retired_count       free-running count of retired instructions
//   bypass_*            last-write forwarding (WB_BYPASS_EN only)
// -----------------------------------------------------------------------------
module wb_stage #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              CLOCK,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              in_valid,
   input  logic              in_reg_write,
   input  logic [ADDR_W-1:0] in_dest,
   input  logic [1:0]        in_wb_sel,
   input  logic [DATA_W-1:0] in_alu_result,
   input  logic [DATA_W-1:0] in_mem_data,
   input  logic [DATA_W-1:0] in_pc_plus4,
   input  logic [1:0]        in_load_size,
   input  logic              in_load_unsigned,
   input  logic [1:0]        in_byte_offset,
   output logic              WriteEnable,
   output logic [ADDR_W-1:0] write_address,
   output logic [DATA_W-1:0] write_data_in,
   output logic              wb_valid,
   output logic              misalign_err,
`ifdef WB_BYPASS_EN
   output logic              bypass_valid,
   output logic [ADDR_W-1:0] bypass_addr,
   output logic [DATA_W-1:0] bypass_data,
`endif
   output logic [31:0]       retired_count
);

   localparam logic [1:0] SEL_ALU  = 2'b00;
   localparam logic [1:0] SEL_LOAD = 2'b01;
   localparam logic [1:0] SEL_LINK = 2'b10;

   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_BYTE = 2'b10;

   // ---------------------------------------------------------------------
   // Stage registers
   // ---------------------------------------------------------------------
   logic              valid_reg;
   logic              fresh_reg;
   logic              reg_write_reg;
   logic [ADDR_W-1:0] dest_reg;
   logic [DATA_W-1:0] wdata_reg;
   logic              misalign_reg;
   logic [31:0]       count_reg;

   logic [DATA_W-1:0] wdata_next;
   logic              misalign_next;

   // ---------------------------------------------------------------------
   // Load lane extraction: the four byte lanes of the raw memory word
   // ---------------------------------------------------------------------
   logic [7:0] byte_lane [4];

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign byte_lane[gi] = in_mem_data[8*gi +: 8];
      end
   endgenerate

   logic [7:0]  sel_byte;
   logic [15:0] sel_half;
   logic [DATA_W-1:0] load_data;

   always_comb begin
      sel_byte = byte_lane[in_byte_offset];
      // A half load uses only offset bit 1. Odd offsets are flagged as
      // misaligned and never write.
      sel_half = in_byte_offset[1] ? in_mem_data[31:16] : in_mem_data[15:0];
      case (in_load_size)
         SIZE_BYTE: load_data = {{24{sel_byte[7]  & ~in_load_unsigned}}, sel_byte};
         SIZE_HALF: load_data = {{16{sel_half[15] & ~in_load_unsigned}}, sel_half};
         default:   load_data = in_mem_data;   // word, and 11 treated as word
      endcase
   end

   always_comb begin
      case (in_wb_sel)
         SEL_LOAD: wdata_next = load_data;
         SEL_LINK: wdata_next = in_pc_plus4;
         default:  wdata_next = in_alu_result; // 00 and 11
      endcase
   end

   // Byte loads can never be misaligned. Half loads need an even offset.
   // Word loads (and size 11) need offset 00.
   always_comb begin
      misalign_next = 1'b0;
      if (in_wb_sel == SEL_LOAD) begin
         if (in_load_size == SIZE_HALF)
            misalign_next = in_byte_offset[0];
         else if (in_load_size != SIZE_BYTE)
            misalign_next = (in_byte_offset != 2'b00);
      end
   end

   // ---------------------------------------------------------------------
   // Capture logic: reset > flush > stall > normal capture
   // ---------------------------------------------------------------------
   logic retire;
   assign retire = valid_reg & fresh_reg;

   always_ff @(posedge CLOCK) begin
      if (reset) begin
         valid_reg     <= 1'b0;
         fresh_reg     <= 1'b0;
         reg_write_reg <= 1'b0;
         dest_reg      <= '0;
         wdata_reg     <= '0;
         misalign_reg  <= 1'b0;
         count_reg     <= '0;
      end else begin
         // The counter tracks the instruction currently in the stage. This is
         // independent of what is captured at this edge. Wraps naturally.
         if (retire)
            count_reg <= count_reg + 32'd1;

         if (flush) begin
            valid_reg <= 1'b0;
            fresh_reg <= 1'b0;
         end else if (stall) begin
            fresh_reg <= 1'b0;
         end else begin
            valid_reg     <= in_valid;
            fresh_reg     <= in_valid;
            reg_write_reg <= in_reg_write;
            dest_reg      <= in_dest;
            wdata_reg     <= wdata_next;
            misalign_reg  <= misalign_next;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign WriteEnable   = retire & reg_write_reg & (dest_reg != '0) & ~misalign_reg;
   assign write_address = dest_reg;
   assign write_data_in = wdata_reg;
   assign wb_valid      = valid_reg;
   assign misalign_err  = retire & misalign_reg;
   assign retired_count = count_reg;

`ifdef WB_BYPASS_EN
   // The last-write register keeps the committed write visible for one more
   // cycle. Flush does not touch it because the write has already happened.
   logic              byp_valid_reg;
   logic [ADDR_W-1:0] byp_addr_reg;
   logic [DATA_W-1:0] byp_data_reg;

   always_ff @(posedge CLOCK) begin
      if (reset) begin
         byp_valid_reg <= 1'b0;
         byp_addr_reg  <= '0;
         byp_data_reg  <= '0;
      end else begin
         byp_valid_reg <= WriteEnable;
         if (WriteEnable) begin
            byp_addr_reg <= dest_reg;
            byp_data_reg <= wdata_reg;
         end
      end
   end

   assign bypass_valid = byp_valid_reg;
   assign bypass_addr  = byp_addr_reg;
   assign bypass_data  = byp_data_reg;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage -- directed self-checking bench for wb_stage
//
// Inputs are driven 1 time unit after each rising edge. Outputs are sampled
// at that same point, which means after the edge that captured the
// instruction. Every expected value below is a hand-computed constant.
// -----------------------------------------------------------------------------
module tb_wb_stage;

   logic        CLOCK = 1'b0;
   logic        reset;
   logic        stall;
   logic        flush;
   logic        in_valid;
   logic        in_reg_write;
   logic [4:0]  in_dest;
   logic [1:0]  in_wb_sel;
   logic [31:0] in_alu_result;
   logic [31:0] in_mem_data;
   logic [31:0] in_pc_plus4;
   logic [1:0]  in_load_size;
   logic        in_load_unsigned;
   logic [1:0]  in_byte_offset;
   logic        WriteEnable;
   logic [4:0]  write_address;
   logic [31:0] write_data_in;
   logic        wb_valid;
   logic        misalign_err;
   logic [31:0] retired_count;
`ifdef WB_BYPASS_EN
   logic        bypass_valid;
   logic [4:0]  bypass_addr;
   logic [31:0] bypass_data;
`endif

   int checks = 0;
   int errors = 0;

   always #5 CLOCK = ~CLOCK;

   wb_stage dut (
      .CLOCK            (CLOCK),
      .reset            (reset),
      .stall            (stall),
      .flush            (flush),
      .in_valid         (in_valid),
      .in_reg_write     (in_reg_write),
      .in_dest          (in_dest),
      .in_wb_sel        (in_wb_sel),
      .in_alu_result    (in_alu_result),
      .in_mem_data      (in_mem_data),
      .in_pc_plus4      (in_pc_plus4),
      .in_load_size     (in_load_size),
      .in_load_unsigned (in_load_unsigned),
      .in_byte_offset   (in_byte_offset),
      .WriteEnable      (WriteEnable),
      .write_address    (write_address),
      .write_data_in    (write_data_in),
      .wb_valid         (wb_valid),
      .misalign_err     (misalign_err),
`ifdef WB_BYPASS_EN
      .bypass_valid     (bypass_valid),
      .bypass_addr      (bypass_addr),
      .bypass_data      (bypass_data),
`endif
      .retired_count    (retired_count)
   );

   task automatic tick();
      @(posedge CLOCK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // One-line transaction log followed by the core output checks.
   task automatic expect_out(input string tag, input logic we, input logic [4:0] addr,
                             input logic [31:0] data, input logic vld,
                             input logic mis, input logic [31:0] cnt);
      $display("%s: WE=%0d addr=%0d data=%h valid=%0d mis=%0d count=%0d",
               tag, WriteEnable, write_address, write_data_in, wb_valid,
               misalign_err, retired_count);
      check({tag, ".we"},    {31'd0, WriteEnable},  {31'd0, we});
      check({tag, ".addr"},  {27'd0, write_address}, {27'd0, addr});
      check({tag, ".data"},  write_data_in,         data);
      check({tag, ".valid"}, {31'd0, wb_valid},     {31'd0, vld});
      check({tag, ".mis"},   {31'd0, misalign_err}, {31'd0, mis});
      check({tag, ".count"}, retired_count,         cnt);
   endtask

   task automatic drive(input logic v, input logic rw, input logic [4:0] dest,
                        input logic [1:0] sel, input logic [31:0] alu,
                        input logic [31:0] mem, input logic [31:0] pc,
                        input logic [1:0] size, input logic uns,
                        input logic [1:0] off);
      in_valid = v; in_reg_write = rw; in_dest = dest; in_wb_sel = sel;
      in_alu_result = alu; in_mem_data = mem; in_pc_plus4 = pc;
      in_load_size = size; in_load_unsigned = uns; in_byte_offset = off;
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; flush = 1'b0;
      drive(1'b0, 1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 2'b00);
      tick(); tick();
      reset = 1'b0;
      expect_out("reset", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'd0);
`ifdef WB_BYPASS_EN
      check("reset.byp_valid", {31'd0, bypass_valid}, 32'd0);
`endif

      // ALU write to r5
      drive(1'b1, 1'b1, 5'd5, 2'b00, 32'h12345678, 32'h0, 32'h0, 2'b00, 1'b0, 2'b00);
      tick();
      expect_out("alu", 1'b1, 5'd5, 32'h12345678, 1'b1, 1'b0, 32'd0);

      // Signed byte load, offset 3 -> lane 0x80
      drive(1'b1, 1'b1, 5'd3, 2'b01, 32'h0, 32'h80FF0000, 32'h0, 2'b10, 1'b0, 2'b11);
      tick();
      expect_out("lb", 1'b1, 5'd3, 32'hFFFFFF80, 1'b1, 1'b0, 32'd1);
`ifdef WB_BYPASS_EN
      check("alu.byp_valid", {31'd0, bypass_valid}, 32'd1);
      check("alu.byp_addr",  {27'd0, bypass_addr}, 32'd5);
      check("alu.byp_data",  bypass_data, 32'h12345678);
`endif

      // Unsigned byte load
      drive(1'b1, 1'b1, 5'd3, 2'b01, 32'h0, 32'h80FF0000, 32'h0, 2'b10, 1'b1, 2'b11);
      tick();
      expect_out("lbu", 1'b1, 5'd3, 32'h00000080, 1'b1, 1'b0, 32'd2);

      // Signed half load, upper half
      drive(1'b1, 1'b1, 5'd4, 2'b01, 32'h0, 32'hBEEF1234, 32'h0, 2'b01, 1'b0, 2'b10);
      tick();
      expect_out("lh", 1'b1, 5'd4, 32'hFFFFBEEF, 1'b1, 1'b0, 32'd3);

      // Misaligned word load: no write, still counted
      drive(1'b1, 1'b1, 5'd6, 2'b01, 32'h0, 32'hCAFEF00D, 32'h0, 2'b00, 1'b0, 2'b01);
      tick();
      expect_out("lw_mis", 1'b0, 5'd6, 32'hCAFEF00D, 1'b1, 1'b1, 32'd4);

      // Bubble: the misalign pulse ends, the count reflects the misaligned load
      drive(1'b0, 1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 2'b00);
      tick();
      check("bubble.mis",   {31'd0, misalign_err}, 32'd0);
      check("bubble.valid", {31'd0, wb_valid},     32'd0);
      check("bubble.count", retired_count,         32'd5);

      // r0 destination: never written
      drive(1'b1, 1'b1, 5'd0, 2'b00, 32'h0000AAAA, 32'h0, 32'h0, 2'b00, 1'b0, 2'b00);
      tick();
      expect_out("r0", 1'b0, 5'd0, 32'h0000AAAA, 1'b1, 1'b0, 32'd5);

      // Link write to r31
      drive(1'b1, 1'b1, 5'd31, 2'b10, 32'h0000DEAD, 32'h0, 32'h00400010, 2'b00, 1'b0, 2'b00);
      tick();
      expect_out("link", 1'b1, 5'd31, 32'h00400010, 1'b1, 1'b0, 32'd6);

      // Capture r7, then stall for 3 cycles with a different instruction on input
      drive(1'b1, 1'b1, 5'd7, 2'b00, 32'h00000077, 32'h0, 32'h0, 2'b00, 1'b0, 2'b00);
      tick();
      expect_out("st_cap", 1'b1, 5'd7, 32'h00000077, 1'b1, 1'b0, 32'd7);
      stall = 1'b1;
      drive(1'b1, 1'b1, 5'd9, 2'b00, 32'h00000099, 32'h0, 32'h0, 2'b00, 1'b0, 2'b00);
      tick();
      expect_out("stall1", 1'b0, 5'd7, 32'h00000077, 1'b1, 1'b0, 32'd8);
      tick();
      expect_out("stall2", 1'b0, 5'd7, 32'h00000077, 1'b1, 1'b0, 32'd8);
      tick();
      expect_out("stall3", 1'b0, 5'd7, 32'h00000077, 1'b1, 1'b0, 32'd8);

      // Flush wins over stall and drops the incoming instruction
      flush = 1'b1;
      drive(1'b1, 1'b1, 5'd10, 2'b00, 32'h000000A0, 32'h0, 32'h0, 2'b00, 1'b0, 2'b00);
      tick();
      check("flush.valid", {31'd0, wb_valid},    32'd0);
      check("flush.we",    {31'd0, WriteEnable}, 32'd0);
      flush = 1'b0; stall = 1'b0;
      drive(1'b0, 1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 2'b00);
      tick();
      check("flush.count", retired_count, 32'd8);

      // Four back-to-back retirements, then r12 captured and stalled
      for (int i = 1; i <= 5; i++) begin
         drive(1'b1, 1'b1, 5'(i == 5 ? 12 : i), 2'b00, 32'(i), 32'h0, 32'h0, 2'b00, 1'b0, 2'b00);
         tick();
      end
      expect_out("pre_rst", 1'b1, 5'd12, 32'd5, 1'b1, 1'b0, 32'd12);
      stall = 1'b1;
      tick();
      check("stall_rst.count", retired_count, 32'd13);

      // Reset during the stall clears everything
      reset = 1'b1;
      tick();
      reset = 1'b0; stall = 1'b0;
      drive(1'b0, 1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 2'b00);
      expect_out("mid_rst", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'd0);
`ifdef WB_BYPASS_EN
      check("mid_rst.byp_valid", {31'd0, bypass_valid}, 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
